ft245_tx_drain: RTL and testbench
=================================

Name: ft245_tx_drain

Overview:
Transmit-side drain for the FT245 byte interface. It pops bytes from the synchronous TX fifo through that fifo's read port (rd_en, registered rd_data, empty) and writes them to the FT245 chip with the TXE#/WR# handshake. The shared bidirectional data bus is obtained through a req/grant handshake with the bus arbiter, which also serves the RX path. One byte is transferred per bus tenure.

Parameters:
wr_setup_cycles, 2, cycles ft_data_out is driven with ft_wr_n high before the strobe (8-bit; 0 treated as 1)
wr_pulse_cycles, 3, cycles ft_wr_n is held low (8-bit; 0 treated as 1)
wr_hold_cycles, 1, cycles data stays driven after ft_wr_n rises (8-bit; 0 treated as 1)
txe_recover_cycles, 4, wait after a write before ft_txe_n is trusted again; must cover the chip's TXE# deassert delay plus 2 sync stages (8-bit; 0 treated as 1)
count_width, 16, width of byte_count

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fifo_rd_en  out  1  fifo read strobe, combinational, one cycle per byte
fifo_rd_data  in  8  fifo registered read data, valid the cycle after fifo_rd_en
fifo_empty  in  1  fifo empty flag
ft_txe_n  in  1  FT245 TXE#, asynchronous, low = chip can accept a byte
ft_wr_n  out  1  FT245 write strobe, registered; byte latched on the rising edge
ft_data_out  out  8  byte driven onto the FT245 bus
ft_data_oe  out  1  bus output enable
bus_req  out  1  request for the shared FT245 bus
bus_grant  in  1  arbiter grant
busy  out  1  high in any state other than IDLE
byte_count  out  count_width  bytes written since reset, wraps modulo 2^count_width

Behaviour:
- Reset (async assert, sync release): state IDLE; ft_wr_n=1, ft_data_oe=0, ft_data_out=0, bus_req=0, busy=0, byte_count=0, fifo_rd_en=0; both txe sync flops =1 (not ready).
- ft_txe_n passes through a 2-flop synchroniser to give txe_s. Only txe_s is used.
- One down-counter times SETUP, STROBE, HOLD and RECOVER. It loads (param−1) on entry to each state. The state exits on the cycle the counter reads 0, so each state lasts exactly max(param,1) cycles.
- FSM:
  - IDLE: outputs inactive. If !fifo_empty, go to REQ.
  - REQ: bus_req=1. If fifo_empty, return to IDLE (bus_req drops). Else if bus_grant && !txe_s: assert fifo_rd_en for this cycle only and go to FETCH. Otherwise stay in REQ.
  - FETCH (1 cycle): bus_req=1. fifo_rd_data is valid; capture it into ft_data_out at the end of the cycle. Go to SETUP.
  - SETUP: ft_data_oe=1, ft_wr_n=1. Go to STROBE.
  - STROBE: ft_wr_n=0, data stable. Go to HOLD.
  - HOLD: ft_wr_n=1, ft_data_oe=1. byte_count increments once, on the entry edge. Go to RECOVER.
  - RECOVER: ft_data_oe=0, bus_req=0. txe_s is ignored. Go to IDLE.
- ft_wr_n and ft_data_oe are registered, decoded from the next state, so they are glitch-free. ft_data_out changes only on the FETCH capture edge.
- bus_grant is sampled only in REQ. The arbiter must not revoke the grant while bus_req=1; a revoke after REQ is ignored.
- ft_txe_n rising during SETUP/STROBE/HOLD is ignored; the sequence completes. ft_txe_n is sampled only in REQ.
- Minimum cycles per byte with defaults: REQ1 + FETCH1 + SETUP2 + STROBE3 + HOLD1 + RECOVER4 + IDLE1 = 13.
- At most one fifo_rd_en per byte written. Data is never popped unless it will be written.
- reset_n asserted mid-transfer: outputs return to reset values immediately, which may truncate the ft_wr_n pulse. The popped byte is lost and byte_count is cleared.

Test Plan:
- Reset values: hold reset_n=0 with fifo_empty=0 and ft_txe_n=0 -> ft_wr_n=1, ft_data_oe=0, bus_req=0, fifo_rd_en=0 throughout; byte_count=0.
- Single byte: fifo holds 0xA5, ft_txe_n=0, bus_grant tied 1 -> exactly one fifo_rd_en; ft_data_out=0xA5 with oe=1 two cycles before ft_wr_n falls; ft_wr_n low 3 cycles; byte_count=1; bus_req low 1 cycle after HOLD.
- Burst: fifo preloaded with 0x00..0x0F -> 16 writes in order, rising edges ≥13 cycles apart, byte_count=16, ends in IDLE once fifo_empty=1.
- TXE# backpressure: ft_txe_n=1 with fifo non-empty -> stays in REQ with no fifo_rd_en and ft_wr_n=1 for 50 cycles; ft_txe_n falls -> first fifo_rd_en exactly 2 cycles after the change (sync latency).
- Arbitration: bus_grant=0 for 20 cycles, then 1 -> bus_req high the whole time, no strobe until the grant; fifo_empty pulsed 1 while in REQ -> returns to IDLE with bus_req low.
- Mid-strobe reset: assert reset_n=0 during the 2nd STROBE cycle -> ft_wr_n=1 and oe=0 asynchronously in the same cycle; after release, byte_count=0 and the next fifo byte is transmitted normally.

Source files
------------

// File: rtl/ft245_tx_drain.sv
// FT245 transmit drain: pops one byte per bus tenure from the TX fifo and
// writes it to the chip with a timed TXE#/WR# sequence on the shared bus.
//
// Handshakes: bus_req rises on entry to REQ and stays high until the write
// sequence ends. Only REQ samples bus_grant. fifo_rd_en is a single-cycle pop,
// and it is raised only when the write that consumes the byte is certain.
module ft245_tx_drain #(
  parameter logic [7:0] wr_setup_cycles    = 8'd2,
  parameter logic [7:0] wr_pulse_cycles    = 8'd3,
  parameter logic [7:0] wr_hold_cycles     = 8'd1,
  parameter logic [7:0] txe_recover_cycles = 8'd4,
  parameter int         count_width        = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_empty,
  input  logic                   ft_txe_n,
  output logic                   ft_wr_n,
  output logic [7:0]             ft_data_out,
  output logic                   ft_data_oe,
  output logic                   bus_req,
  input  logic                   bus_grant,
  output logic                   busy,
  output logic [count_width-1:0] byte_count,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FETCH   = 3'd2,
    SETUP   = 3'd3,
    STROBE  = 3'd4,
    HOLD    = 3'd5,
    RECOVER = 3'd6
  } state_t;

  // Counter reload values: a zero parameter behaves like one cycle.
  localparam logic [7:0] SETUP_LD = (wr_setup_cycles == 8'd0) ? 8'd0 : wr_setup_cycles - 8'd1;
  localparam logic [7:0] PULSE_LD = (wr_pulse_cycles == 8'd0) ? 8'd0 : wr_pulse_cycles - 8'd1;
  localparam logic [7:0] HOLD_LD  = (wr_hold_cycles == 8'd0) ? 8'd0 : wr_hold_cycles - 8'd1;
  localparam logic [7:0] REC_LD   = (txe_recover_cycles == 8'd0) ? 8'd0 : txe_recover_cycles - 8'd1;
  localparam logic [count_width-1:0] COUNT_ONE = {{(count_width-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   txe_meta_q, txe_s_q;
  logic                   wr_n_q, oe_q, req_q, busy_q;
  logic [7:0]             data_q;
  logic [count_width-1:0] count_q;
  logic                   rd_en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = REQ;
      end
      REQ: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (bus_grant && !txe_s_q) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = RECOVER;
          cnt_d   = REC_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        // TXE# is not trusted until the recover window has elapsed.
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing outputs are decoded from state_d so they change cleanly on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= 8'd0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txe_meta_q <= ft_txe_n;
      txe_s_q    <= txe_meta_q;
      wr_n_q     <= (state_d != STROBE);
      oe_q       <= (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      req_q      <= (state_d == REQ) || (state_d == FETCH) || (state_d == SETUP) ||
                    (state_d == STROBE) || (state_d == HOLD);
      busy_q     <= (state_d != IDLE);
      if (state_q == FETCH) data_q <= fifo_rd_data;
      if ((state_q == STROBE) && (state_d == HOLD)) count_q <= count_q + COUNT_ONE;
    end
  end

  assign fifo_rd_en  = rd_en_d;
  assign ft_wr_n     = wr_n_q;
  assign ft_data_oe  = oe_q;
  assign ft_data_out = data_q;
  assign bus_req     = req_q;
  assign busy        = busy_q;
  assign byte_count  = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ft245_tx_drain.sv
// Directed bench for ft245_tx_drain: behavioural TX fifo, write monitor on
// WR# rising edges, one task per scenario with inline checks.
module tb_ft245_tx_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        ft_txe_n;
  logic        ft_wr_n;
  logic [7:0]  ft_data_out;
  logic        ft_data_oe;
  logic        bus_req;
  logic        bus_grant;
  logic        busy;
  logic [15:0] byte_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  logic empty_force = 1'b0;
  logic mon_en = 1'b1;
  logic wr_prev = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int rise_q [$];
  logic [15:0] exp_count = 16'd0;

  ft245_tx_drain dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .ft_txe_n     (ft_txe_n),
    .ft_wr_n      (ft_wr_n),
    .ft_data_out  (ft_data_out),
    .ft_data_oe   (ft_data_oe),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .busy         (busy),
    .byte_count   (byte_count),
    .dbg_state    (dbg_state)
  );

  // clock / fifo model / monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (push_cnt == pop_cnt) || empty_force;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[pop_cnt[7:0]];
      pop_cnt      <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_count = rd_count + 1;
    if (mon_en && ft_wr_n && !wr_prev) begin
      rx_q.push_back(ft_data_out);
      rise_q.push_back(cyc);
    end
    wr_prev = ft_wr_n;
  end

  task automatic push_byte(input logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    exp_q.push_back(b);
    push_cnt = push_cnt + 1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    ft_txe_n  = 1'b0;
    bus_grant = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ft_wr_n, ft_data_oe, bus_req, fifo_rd_en, busy} !== 5'b10000 || byte_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: wr_n=%b oe=%b req=%b rd_en=%b busy=%b count=%0d want 1 0 0 0 0 0",
                 i, ft_wr_n, ft_data_oe, bus_req, fifo_rd_en, busy, byte_count);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    bit exp_wr [13]  = '{1,1,1,1,0,0,0,1,1,1,1,1,1};
    bit exp_oe [13]  = '{0,0,1,1,1,1,1,1,0,0,0,0,0};
    bit exp_req [13] = '{1,1,1,1,1,1,1,1,0,0,0,0,0};
    bit exp_bsy [13] = '{1,1,1,1,1,1,1,1,1,1,1,1,0};
    int n = 0;
    int rd0 = rd_count;
    rx_q.delete();
    while (!fifo_rd_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fifo_rd_en) begin
      errors++;
      $display("FAIL single_rd_en_timeout: rd_en=%b want 1", fifo_rd_en);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (ft_wr_n !== exp_wr[i] || ft_data_oe !== exp_oe[i] || bus_req !== exp_req[i] || busy !== exp_bsy[i]) begin
        errors++;
        $display("FAIL single_seq cyc %0d: wr_n=%b oe=%b req=%b busy=%b want %b %b %b %b",
                 i, ft_wr_n, ft_data_oe, bus_req, busy, exp_wr[i], exp_oe[i], exp_req[i], exp_bsy[i]);
      end
      if (i == 2) begin
        checks++;
        if (ft_data_out !== 8'hA5) begin
          errors++;
          $display("FAIL single_data_setup: got %h want a5", ft_data_out);
        end
      end
      if (i == 7) begin
        checks++;
        if (byte_count !== 16'd1) begin
          errors++;
          $display("FAIL single_count_hold: got %0d want 1", byte_count);
        end
      end
      @(negedge clk);
    end
    exp_count = 16'd1;
    checks++;
    if (rd_count - rd0 !== 1) begin
      errors++;
      $display("FAIL single_rd_en_count: got %0d want 1", rd_count - rd0);
    end
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_written: count %0d want 1 byte a5", rx_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_burst;
    int n = 0;
    int rd0 = rd_count;
    logic [7:0] got;
    rx_q.delete();
    rise_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) push_byte(i[7:0]);
    @(negedge clk);
    while ((rx_q.size() < 16 || busy || !fifo_empty) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL burst_timeout: written %0d want 16", rx_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL burst_data %0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    for (int i = 1; i < rise_q.size(); i++) begin
      checks++;
      if (rise_q[i] - rise_q[i-1] < 13) begin
        errors++;
        $display("FAIL burst_spacing %0d: got %0d want >=13", i, rise_q[i] - rise_q[i-1]);
      end
    end
    exp_count = exp_count + 16'd16;
    checks++;
    if (byte_count !== exp_count || rd_count - rd0 !== 16) begin
      errors++;
      $display("FAIL burst_count: count %0d rd_en %0d want %0d 16", byte_count, rd_count - rd0, exp_count);
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL burst_idle: busy=%b state=%0d want 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_txe_backpressure;
    int n = 0;
    ft_txe_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    push_byte(8'h77);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({fifo_rd_en, ft_wr_n, bus_req} !== 3'b011) begin
        errors++;
        $display("FAIL txe_hold cyc %0d: rd_en=%b wr_n=%b req=%b want 0 1 1", i, fifo_rd_en, ft_wr_n, bus_req);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 ft_txe_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL txe_sync_c0: rd_en=%b want 0", fifo_rd_en);
    end
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL txe_sync_c1: rd_en=%b want 0", fifo_rd_en);
    end
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL txe_sync_c2: rd_en=%b want 1", fifo_rd_en);
    end
    while ((rx_q.size() < 1 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_count = exp_count + 16'd1;
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h77 || byte_count !== exp_count) begin
      errors++;
      $display("FAIL txe_write: bytes %0d count %0d want 1 byte 77 count %0d", rx_q.size(), byte_count, exp_count);
    end
  endtask

  task automatic test_arbitration;
    int n = 0;
    rx_q.delete();
    exp_q.delete();
    bus_grant = 1'b0;
    push_byte(8'h96);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({fifo_rd_en, ft_wr_n, bus_req, busy} !== 4'b0111) begin
        errors++;
        $display("FAIL arb_wait cyc %0d: rd_en=%b wr_n=%b req=%b busy=%b want 0 1 1 1",
                 i, fifo_rd_en, ft_wr_n, bus_req, busy);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL arb_grant: rd_en=%b want 1", fifo_rd_en);
    end
    while ((rx_q.size() < 1 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_count = exp_count + 16'd1;
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h96 || byte_count !== exp_count) begin
      errors++;
      $display("FAIL arb_write: bytes %0d count %0d want 1 byte 96 count %0d", rx_q.size(), byte_count, exp_count);
    end
    // fifo_empty pulse while waiting in REQ
    rx_q.delete();
    exp_q.delete();
    bus_grant = 1'b0;
    push_byte(8'h69);
    repeat (3) @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL arb_req_before_pulse: req=%b want 1", bus_req);
    end
    @(posedge clk);
    #1 empty_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_empty_abort: req=%b busy=%b want 0 0", bus_req, busy);
    end
    @(posedge clk);
    #1 empty_force = 1'b0;
    bus_grant = 1'b1;
    n = 0;
    @(negedge clk);
    while ((rx_q.size() < 1 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_count = exp_count + 16'd1;
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h69 || byte_count !== exp_count) begin
      errors++;
      $display("FAIL arb_after_pulse: bytes %0d count %0d want 1 byte 69 count %0d", rx_q.size(), byte_count, exp_count);
    end
  endtask

  task automatic test_mid_strobe_reset;
    int n = 0;
    mon_en = 1'b0;
    exp_q.delete();
    push_byte(8'h3C);
    while (ft_wr_n !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ft_wr_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_strobe_timeout: wr_n=%b want 0", ft_wr_n);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ft_wr_n, ft_data_oe, bus_req, busy} !== 4'b1000 || byte_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: wr_n=%b oe=%b req=%b busy=%b count=%0d want 1 0 0 0 0",
               ft_wr_n, ft_data_oe, bus_req, busy, byte_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_count = 16'd0;
    rx_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    push_byte(8'h5A);
    n = 0;
    @(negedge clk);
    while ((rx_q.size() < 1 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_count = 16'd1;
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A || byte_count !== exp_count) begin
      errors++;
      $display("FAIL rst_recover: bytes %0d count %0d want 1 byte 5a count 1", rx_q.size(), byte_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_txe_backpressure();
    test_arbitration();
    test_mid_strobe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
